// File: rtl/motor_pkg.sv
// Shared motor-control types: FSM state encoding, sector constants and the
// hall-to-sector and sector-to-gate-pattern lookup tables (forward direction).
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [2:0] SECTOR_INVALID = 3'd7;

  // Gate masks for one commutation step, bit order {C,B,A}.
  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } gate_pat_t;

  // Hall code {h3,h2,h1} to sector 0..5; 000 and 111 are impossible codes.
  function automatic logic [2:0] hall_to_sector(input logic [2:0] h);
    case (h)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      3'b001:  return 3'd5;
      default: return SECTOR_INVALID;
    endcase
  endfunction

  // Forward commutation table: hi = phase driven by PWM, lo = phase tied low.
  function automatic gate_pat_t sector_to_pattern(input logic [2:0] s);
    case (s)
      3'd0:    return '{hi: 3'b001, lo: 3'b010}; // A+ B-
      3'd1:    return '{hi: 3'b001, lo: 3'b100}; // A+ C-
      3'd2:    return '{hi: 3'b010, lo: 3'b100}; // B+ C-
      3'd3:    return '{hi: 3'b010, lo: 3'b001}; // B+ A-
      3'd4:    return '{hi: 3'b100, lo: 3'b001}; // C+ A-
      3'd5:    return '{hi: 3'b100, lo: 3'b010}; // C+ B-
      default: return '{hi: 3'b000, lo: 3'b000};
    endcase
  endfunction

endpackage

// File: rtl/hall_filter.sv
// Hall input conditioning: 2-FF synchroniser followed by a stability filter.
// A new code is accepted once the synchronised value has been seen on
// HALL_FILTER consecutive clocks; accept pulses for one cycle alongside it.
module hall_filter #(
  parameter int HALL_FILTER = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] hall,
  output logic [2:0] code,
  output logic       accept
);

  localparam int              CW       = $clog2(HALL_FILTER + 1);
  localparam logic [CW-1:0]   FILT_MAX = CW'(HALL_FILTER);

  logic [2:0]    sync1, sync2;
  logic [2:0]    cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] run_len;
  logic          accept_now;

  // Bring the asynchronous hall pins into the clk domain.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, giving a true two-stage pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= hall;
      sync2 <= sync1;
    end
  end

  // Length of the current run of identical samples, saturating at FILT_MAX.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    run_len = CW'(1);
    if (sync2 == cand) begin
      run_len = (cnt == FILT_MAX) ? cnt : cnt + 1'b1;
    end
  end

  assign accept_now = (run_len == FILT_MAX) && (sync2 != code);

  // Track the candidate run and commit it once it has been stable long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand   <= 3'b000;
      cnt    <= '0;
      code   <= 3'b000;
      accept <= 1'b0;
    end else begin
      cand   <= sync2;
      cnt    <= run_len;
      accept <= accept_now;
      if (accept_now) code <= sync2;
    end
  end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation sequencer: filtered halls -> sector -> gate
// pattern with dead-time on every change; high side chopped by pwm_in.
// Optional macro STALL_DETECT_EN adds a stall timeout that faults in RUN.
module bldc_commutator
  import motor_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 32,
  parameter int HALL_FILTER     = 8,
  parameter int STALL_TIMEOUT   = 3_200_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               dir,
  input  logic               pwm_in,
  input  logic [2:0]         hall,
  output logic [2:0]         inh,
  output logic [2:0]         inl,
  output logic [2:0]         sector,
  output logic               fault,
  output logic signed [23:0] comm_count
);

  // Dead time is DEADTIME_CYCLES cycles in DEAD, so load one less and leave at 0.
  localparam int            DW        = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME_CYCLES - 1);

  state_t        state, state_next;
  logic [2:0]    code;
  logic          accept;
  logic [2:0]    sector_q;
  logic          dir_q;
  logic          hall_seen;
  logic [DW-1:0] dead_cnt;
  logic          dead_load;
  logic          sector_valid;
  logic          change;
  logic          stall_hit;
  gate_pat_t     pat_fwd, pat;
  logic [2:0]    sector_inc, sector_dec;

  hall_filter #(.HALL_FILTER(HALL_FILTER)) u_hall_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .hall    (hall),
    .code    (code),
    .accept  (accept)
  );

  assign sector       = hall_to_sector(code);
  assign sector_valid = (sector != SECTOR_INVALID);
  assign change       = (sector != sector_q) || (dir != dir_q);
  assign fault        = (state == FAULT);

  // Reverse direction swaps the roles of the two conducting phases.
  assign pat_fwd = sector_to_pattern(sector);
  assign pat     = dir ? '{hi: pat_fwd.lo, lo: pat_fwd.hi} : pat_fwd;

  // Previous sector/dir for change detection; hall_seen blocks a fault on the
  // reset code 000 before the filter has accepted any real hall value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sector_q  <= SECTOR_INVALID;
      dir_q     <= 1'b0;
      hall_seen <= 1'b0;
    end else begin
      sector_q <= sector;
      dir_q    <= dir;
      if (accept) hall_seen <= 1'b1;
    end
  end

`ifdef STALL_DETECT_EN
  localparam int            SW         = $clog2(STALL_TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);
  logic [SW-1:0] stall_cnt;

  // Cycles spent in RUN since the last accepted hall change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       stall_cnt <= '0;
    else if (state != RUN || accept)    stall_cnt <= '0;
    else                                stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_hit = (state == RUN) && (stall_cnt == STALL_LAST);
`else
  // Stall detection is compiled out; STALL_TIMEOUT has no effect.
  logic unused_stall_timeout;
  assign unused_stall_timeout = (STALL_TIMEOUT != 0);
  assign stall_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; enable low overrides everything and returns to IDLE.
  always_comb begin
    state_next = state;
    dead_load  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sector_valid) begin
            state_next = DEAD;
            dead_load  = 1'b1;
          end else if (hall_seen) begin
            state_next = FAULT;
          end
        end
        DEAD: begin
          if (!sector_valid)        state_next = FAULT;
          else if (change)          dead_load  = 1'b1;
          else if (dead_cnt == '0)  state_next = RUN;
        end
        RUN: begin
          if (!sector_valid) begin
            state_next = FAULT;
          end else if (change) begin
            state_next = DEAD;
            dead_load  = 1'b1;
          end else if (stall_hit) begin
            state_next = FAULT;
          end
        end
        FAULT:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Dead-time down-counter, restarted on every pattern change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            dead_cnt <= '0;
    else if (dead_load)                      dead_cnt <= DEAD_LOAD;
    else if (state == DEAD && dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
  end

  // Registered gate drive: only RUN drives a pattern, so the two sides of a
  // leg can never be on together and all gates drop the cycle RUN is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inh <= 3'b000;
      inl <= 3'b000;
    end else if (state_next == RUN) begin
      inh <= pat.hi & {3{pwm_in}};
      inl <= pat.lo;
    end else begin
      inh <= 3'b000;
      inl <= 3'b000;
    end
  end

  assign sector_inc = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
  assign sector_dec = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;

  // Signed position count: adjacent steps only; jumps and invalid codes ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      comm_count <= '0;
    end else if (accept && sector_valid && sector_q != SECTOR_INVALID) begin
      if (sector == sector_inc)      comm_count <= comm_count + 24'sd1;
      else if (sector == sector_dec) comm_count <= comm_count - 24'sd1;
    end
  end

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed testbench for bldc_commutator (DEADTIME 32, HALL_FILTER 8,
// STALL_TIMEOUT 1000). Stall expectations follow STALL_DETECT_EN.
module tb_bldc_commutator;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               dir;
  logic               pwm_in;
  logic [2:0]         hall;
  logic [2:0]         inh;
  logic [2:0]         inl;
  logic [2:0]         sector;
  logic               fault;
  logic signed [23:0] comm_count;

  int n_cmp = 0;
  int n_err = 0;

  bldc_commutator #(
    .DEADTIME_CYCLES (32),
    .HALL_FILTER     (8),
    .STALL_TIMEOUT   (1000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .dir        (dir),
    .pwm_in     (pwm_in),
    .hall       (hall),
    .inh        (inh),
    .inl        (inl),
    .sector     (sector),
    .fault      (fault),
    .comm_count (comm_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_gates(input string tag, input logic [2:0] eh, input logic [2:0] el);
    check({tag, "_inh"}, 32'(inh), 32'(eh));
    check({tag, "_inl"}, 32'(inl), 32'(el));
  endtask

  // Apply a hall code from RUN and follow it through filter, dead gap and new pattern.
  task automatic hall_step(input string tag, input logic [2:0] hv, input logic [2:0] es,
                           input logic [2:0] eh, input logic [2:0] el, input logic [23:0] ec);
    int zeros;
    hall = hv;
    tick(10);
    check({tag, "_sector"}, 32'(sector), 32'(es));
    zeros = 0;
    repeat (33) begin
      tick(1);
      if (inh == 3'b000 && inl == 3'b000) zeros++;
    end
    check({tag, "_gap"}, 32'(zeros), 32'd32);
    check_gates(tag, eh, el);
    check({tag, "_count"}, 32'($unsigned(comm_count)), 32'(ec));
  endtask

  // Shoot-through guard on every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) check("no_shoot_through", 32'(inh & inl), 32'd0);
  end

  initial begin
    int bad;
    reset_n = 1'b0; enable = 1'b0; dir = 1'b0; pwm_in = 1'b1; hall = 3'b000;
    tick(3);
    check("rst_sector", 32'(sector), 32'd7);
    check("rst_fault",  32'(fault),  32'd0);
    check("rst_count",  32'($unsigned(comm_count)), 32'd0);
    check_gates("rst", 3'b000, 3'b000);

    // Start-up: sector after 2+8 cycles, gates DEADTIME+1 later.
    reset_n = 1'b1; enable = 1'b1; hall = 3'b101;
    tick(9);
    check("start_sector_early", 32'(sector), 32'd7);
    tick(1);
    check("start_sector", 32'(sector), 32'd0);
    tick(32);
    check_gates("start_dead", 3'b000, 3'b000);
    tick(1);
    check_gates("start_run", 3'b001, 3'b010);
    check("start_count", 32'($unsigned(comm_count)), 32'd0);

    // PWM chops only the active high-side gate, one register stage later.
    pwm_in = 1'b0; tick(1);
    check_gates("pwm_low", 3'b000, 3'b010);
    pwm_in = 1'b1; tick(1);
    check_gates("pwm_high", 3'b001, 3'b010);

    // Reverse rotation: 0->5 wraps count to -1, full turn reaches -6.
    hall_step("rev1", 3'b001, 3'd5, 3'b100, 3'b010, 24'hFFFFFF);
    hall_step("rev2", 3'b011, 3'd4, 3'b100, 3'b001, 24'hFFFFFE);
    hall_step("rev3", 3'b010, 3'd3, 3'b010, 3'b001, 24'hFFFFFD);
    hall_step("rev4", 3'b110, 3'd2, 3'b010, 3'b100, 24'hFFFFFC);
    hall_step("rev5", 3'b100, 3'd1, 3'b001, 3'b100, 24'hFFFFFB);
    hall_step("rev6", 3'b101, 3'd0, 3'b001, 3'b010, 24'hFFFFFA);

    // Forward rotation: +6 brings the count back to zero, including 5->0.
    hall_step("fwd1", 3'b100, 3'd1, 3'b001, 3'b100, 24'hFFFFFB);
    hall_step("fwd2", 3'b110, 3'd2, 3'b010, 3'b100, 24'hFFFFFC);
    hall_step("fwd3", 3'b010, 3'd3, 3'b010, 3'b001, 24'hFFFFFD);
    hall_step("fwd4", 3'b011, 3'd4, 3'b100, 3'b001, 24'hFFFFFE);
    hall_step("fwd5", 3'b001, 3'd5, 3'b100, 3'b010, 24'hFFFFFF);
    hall_step("fwd6", 3'b101, 3'd0, 3'b001, 3'b010, 24'h000000);

    // Direction flip in S0: immediate dead gap, then swapped roles.
    dir = 1'b1; tick(1);
    check_gates("dir_dead_first", 3'b000, 3'b000);
    tick(31);
    check_gates("dir_dead_last", 3'b000, 3'b000);
    tick(1);
    check_gates("dir_rev", 3'b010, 3'b001);
    pwm_in = 1'b0; tick(1);
    check_gates("dir_rev_pwm_low", 3'b000, 3'b001);
    pwm_in = 1'b1; dir = 1'b0; tick(33);
    check_gates("dir_fwd", 3'b001, 3'b010);

    // 5-cycle glitch to 100 is shorter than the filter and must leave no trace.
    bad = 0;
    hall = 3'b100;
    repeat (5) begin
      tick(1);
      if (sector != 3'd0 || inh != 3'b001 || inl != 3'b010) bad++;
    end
    hall = 3'b101;
    repeat (20) begin
      tick(1);
      if (sector != 3'd0 || inh != 3'b001 || inl != 3'b010) bad++;
    end
    check("glitch_bad_cycles", 32'(bad), 32'd0);
    check("glitch_count", 32'($unsigned(comm_count)), 32'd0);

    // Two-sector jumps commutate but leave the count alone.
    hall_step("jump1", 3'b110, 3'd2, 3'b010, 3'b100, 24'h000000);
    hall_step("jump2", 3'b101, 3'd0, 3'b001, 3'b010, 24'h000000);

    // Invalid hall code in RUN latches a fault.
    hall = 3'b111;
    tick(10);
    check("inv_sector", 32'(sector), 32'd7);
    check("inv_fault_early", 32'(fault), 32'd0);
    tick(1);
    check("inv_fault", 32'(fault), 32'd1);
    check_gates("inv", 3'b000, 3'b000);
    tick(20);
    check("inv_fault_held", 32'(fault), 32'd1);
    enable = 1'b0; tick(1);
    check("inv_clear", 32'(fault), 32'd0);
    enable = 1'b1; tick(1);
    check("inv_refault", 32'(fault), 32'd1);
    enable = 1'b0; hall = 3'b101; tick(10);
    check("recover_sector", 32'(sector), 32'd0);
    check("recover_fault", 32'(fault), 32'd0);
    check("recover_count", 32'($unsigned(comm_count)), 32'd0);
    enable = 1'b1; tick(32);
    check_gates("recover_dead", 3'b000, 3'b000);
    tick(1);
    check_gates("recover_run", 3'b001, 3'b010);

    // enable low mid-RUN and mid-DEAD drops the gates on the next clock.
    enable = 1'b0; tick(1);
    check_gates("off_run", 3'b000, 3'b000);
    enable = 1'b1; tick(33);
    check_gates("on_again", 3'b001, 3'b010);
    dir = 1'b1; tick(5);
    enable = 1'b0; tick(1);
    check_gates("off_dead", 3'b000, 3'b000);
    check("off_dead_fault", 32'(fault), 32'd0);
    dir = 1'b0; enable = 1'b1; tick(33);
    check_gates("stall_start", 3'b001, 3'b010);

    // Frozen halls in RUN.
`ifdef STALL_DETECT_EN
    tick(999);
    check("stall_before", 32'(fault), 32'd0);
    tick(1);
    check("stall_fault", 32'(fault), 32'd1);
    check_gates("stall_gates", 3'b000, 3'b000);
`else
    tick(1100);
    check("no_stall_fault", 32'(fault), 32'd0);
    check_gates("no_stall_gates", 3'b001, 3'b010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
